ras_checkpoint_queue: RTL

Circular queue, in program order, of RAS checkpoints for in-flight RAS-relevant branches. It sits between the fetch stage, which produces one `RAS_CheckpointData` per fetch lane, and the RAS recovery port. It captures checkpoints at fetch and hands out tags that travel with the branches. On a branch misprediction it squashes all younger entries and drives `recoverBrHistory` and `recoveredRasCheckpoint` to the RAS.

---
 rtl/ras_checkpoint_queue_pkg.sv | 13 +
 rtl/ras_checkpoint_ram.sv | 20 ++
 rtl/ras_checkpoint_queue.sv | 71 +++++++
 3 files changed

// File: rtl/ras_checkpoint_queue_pkg.sv
// ras_checkpoint_queue_pkg: fetch-unit types shared by the RAS checkpoint queue and its storage.
package ras_checkpoint_queue_pkg;
   localparam int FETCH_WIDTH = 2;
   localparam int RAS_CHECKPOINT_QUEUE_ENTRY_NUM = 16;
   localparam int RAS_STACK_PTR_WIDTH = 4;
   localparam int RAS_QUEUE_PTR_WIDTH = 4;
   typedef logic [$clog2(RAS_CHECKPOINT_QUEUE_ENTRY_NUM)-1:0] RAS_CheckpointQueueIndexPath;
   typedef logic [$clog2(RAS_CHECKPOINT_QUEUE_ENTRY_NUM):0] RAS_CheckpointTag;
   typedef struct packed {
      logic [RAS_STACK_PTR_WIDTH-1:0] stackTopPtr;
      logic [RAS_QUEUE_PTR_WIDTH-1:0] queueTailPtr;
   } RAS_CheckpointData;
endpackage

// File: rtl/ras_checkpoint_ram.sv
// ras_checkpoint_ram: checkpoint storage with one write port per fetch lane and one async read port.
module ras_checkpoint_ram
   import ras_checkpoint_queue_pkg::*;
#(
   parameter int ENTRY_NUM = RAS_CHECKPOINT_QUEUE_ENTRY_NUM,
   localparam int IDX_W = $clog2(ENTRY_NUM)
)(
   input  logic                                  clk,
   input  logic [FETCH_WIDTH-1:0]                writeEnable,
   input  logic [FETCH_WIDTH-1:0][IDX_W-1:0]     writeIndex,
   input  RAS_CheckpointData [FETCH_WIDTH-1:0]   writeData,
   input  logic [IDX_W-1:0]                      readIndex,
   output RAS_CheckpointData                     readData
);
   RAS_CheckpointData entries [ENTRY_NUM];
   always_ff @(posedge clk)
      for (int i = 0; i < FETCH_WIDTH; i++)
         if (writeEnable[i]) entries[writeIndex[i]] <= writeData[i];
   assign readData = entries[readIndex];
endmodule

// File: rtl/ras_checkpoint_queue.sv
// ras_checkpoint_queue: program-order queue of RAS checkpoints; allocates tags at fetch and
// restores the checkpoint of a mispredicted branch while squashing everything younger.
module ras_checkpoint_queue
   import ras_checkpoint_queue_pkg::*;
#(
   parameter int ENTRY_NUM = RAS_CHECKPOINT_QUEUE_ENTRY_NUM,
   parameter int RELEASE_WIDTH = 2,
   localparam int IDX_W = $clog2(ENTRY_NUM),
   localparam int PTR_W = IDX_W + 1,
   localparam int REL_W = $clog2(RELEASE_WIDTH + 1)
)(
   input  logic                                clk,
   input  logic                                rst,
   input  logic [FETCH_WIDTH-1:0]              allocValid,
   input  RAS_CheckpointData [FETCH_WIDTH-1:0] allocCheckpoint,
   output logic                                allocReady,
   output logic [FETCH_WIDTH-1:0][PTR_W-1:0]   allocTag,
   input  logic [REL_W-1:0]                    releaseNum,
   input  logic                                recoverValid,
   input  logic [PTR_W-1:0]                    recoverTag,
   input  logic                                flushAll,
   output logic                                recoverBrHistory,
   output RAS_CheckpointData                   recoveredRasCheckpoint,
   output logic [PTR_W-1:0]                    count
);
   logic [PTR_W-1:0] headPtr, tailPtr, allocCnt, headNext;
   logic [FETCH_WIDTH-1:0][IDX_W-1:0] writeIndex;
   logic allocFire, releaseOk;
   RAS_CheckpointData readData;
   // Valid lanes are packed in lane order, so each lane's tag is tail plus the valid lanes before it.
   always_comb begin
      allocCnt = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         allocTag[i] = tailPtr + allocCnt;
         writeIndex[i] = allocTag[i][IDX_W-1:0];
         allocCnt = allocCnt + PTR_W'(allocValid[i]);
      end
   end
   always_comb begin
      count = tailPtr - headPtr;
      allocReady = count <= PTR_W'(ENTRY_NUM - FETCH_WIDTH);
      allocFire = allocReady & ~recoverValid & ~flushAll;
      releaseOk = PTR_W'(releaseNum) <= count;
      headNext = headPtr + (releaseOk ? PTR_W'(releaseNum) : '0);
   end
   ras_checkpoint_ram #(.ENTRY_NUM(ENTRY_NUM)) ram (
      .clk(clk),
      .writeEnable({FETCH_WIDTH{allocFire}} & allocValid),
      .writeIndex(writeIndex),
      .writeData(allocCheckpoint),
      .readIndex(recoverTag[IDX_W-1:0]),
      .readData(readData)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         headPtr <= '0;
         tailPtr <= '0;
         recoverBrHistory <= 1'b0;
         recoveredRasCheckpoint <= '0;
      end else begin
         recoverBrHistory <= recoverValid & ~flushAll;
         if (flushAll) headPtr <= tailPtr;
         else begin
            headPtr <= headNext;
            tailPtr <= recoverValid ? recoverTag + PTR_W'(1) : allocFire ? tailPtr + allocCnt : tailPtr;
            if (recoverValid) recoveredRasCheckpoint <= readData;
         end
      end
   assert property (@(posedge clk) disable iff (rst) releaseOk);
   assert property (@(posedge clk) disable iff (rst) recoverValid |-> PTR_W'(recoverTag - headPtr) < count);
endmodule
